// File: rtl/key_debounce_multi_if.sv
// Key conditioner bus: raw pad levels and enable in, conditioned levels and
// one-cycle event pulses out.
//   en            global enable (0 forces every channel idle)
//   key_in        raw pad levels, asynchronous to clk
//   key_state     debounced level, 1 = pressed
//   press_pulse   one-cycle pulse on accepted press
//   release_pulse one-cycle pulse on accepted release
//   long_pulse    one-cycle pulse when a hold reaches the long-press time
//   repeat_pulse  one-cycle auto-repeat pulse during a long hold
//   key_any       OR of key_state
interface key_debounce_multi_if #(
  parameter int unsigned NUM_KEYS = 4
);
  logic                en;
  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_state;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [NUM_KEYS-1:0] long_pulse;
  logic [NUM_KEYS-1:0] repeat_pulse;
  logic                key_any;

  modport master (
    output en, key_in,
    input  key_state, press_pulse, release_pulse, long_pulse, repeat_pulse, key_any
  );

  modport slave (
    input  en, key_in,
    output key_state, press_pulse, release_pulse, long_pulse, repeat_pulse, key_any
  );
endinterface

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: per channel a 2-FF synchroniser, a
// debounce/hold FSM with one counter, and registered event pulses.
//   clk    system clock
//   rst_n  asynchronous reset, active-low
//   bus    key_debounce_multi_if.slave (en/key_in in, conditioned outputs out)
module key_debounce_multi #(
  parameter int unsigned NUM_KEYS     = 4,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned DEBOUNCE_CYC = 20000,
  parameter int unsigned LONG_CYC     = 200000,
  parameter int unsigned REPEAT_CYC   = 40000,
  parameter int unsigned CNT_W        = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_debounce_multi_if.slave  bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRESS_WT  = 3'd1;
  localparam logic [2:0] ST_HELD      = 3'd2;
  localparam logic [2:0] ST_LONG_HELD = 3'd3;
  localparam logic [2:0] ST_REL_WT    = 3'd4;

  localparam logic [CNT_W-1:0] DEB_TERM  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYC - 1);
  localparam logic             LONG_EN   = (LONG_CYC != 0);
  localparam logic             REP_EN    = (REPEAT_CYC != 0);
  // Synchroniser reset value is the released pad level.
  localparam logic [NUM_KEYS-1:0] SYNC_RST = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] p_c;

  logic [2:0]          state_q [NUM_KEYS];
  logic [2:0]          state_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];

  logic [NUM_KEYS-1:0] key_state_q, key_state_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] long_q, long_d;
  logic [NUM_KEYS-1:0] repeat_q, repeat_d;
  logic                key_any_q, key_any_d;

  // Synchroniser and polarity normalisation (p_c: 1 = pressed).
  always_comb begin
    sync1_d = bus.key_in;
    sync2_d = sync1_q;
    p_c     = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  end

  // Per-channel next-state, counter and output logic.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i]     = state_q[i];
      cnt_d[i]       = cnt_q[i];
      key_state_d[i] = key_state_q[i];
      press_d[i]     = 1'b0;
      release_d[i]   = 1'b0;
      long_d[i]      = 1'b0;
      repeat_d[i]    = 1'b0;

      if (!bus.en) begin
        state_d[i]     = ST_IDLE;
        cnt_d[i]       = '0;
        key_state_d[i] = 1'b0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            cnt_d[i]       = '0;
            key_state_d[i] = 1'b0;
            if (p_c[i]) state_d[i] = ST_PRESS_WT;
          end
          ST_PRESS_WT: begin
            if (!p_c[i]) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == DEB_TERM) begin
              state_d[i]     = ST_HELD;
              cnt_d[i]       = '0;
              key_state_d[i] = 1'b1;
              press_d[i]     = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          ST_HELD: begin
            key_state_d[i] = 1'b1;
            if (!p_c[i]) begin
              state_d[i] = ST_REL_WT;
              cnt_d[i]   = '0;
            end else if (LONG_EN) begin
              if (cnt_q[i] == LONG_TERM) begin
                state_d[i] = ST_LONG_HELD;
                cnt_d[i]   = '0;
                long_d[i]  = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
              end
            end
          end
          ST_LONG_HELD: begin
            key_state_d[i] = 1'b1;
            if (!p_c[i]) begin
              state_d[i] = ST_REL_WT;
              cnt_d[i]   = '0;
            end else if (REP_EN) begin
              if (cnt_q[i] == REP_TERM) begin
                cnt_d[i]    = '0;
                repeat_d[i] = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
              end
            end
          end
          ST_REL_WT: begin
            key_state_d[i] = 1'b1;
            if (p_c[i]) begin
              // Bounce during release: back to HELD, long timer restarts.
              state_d[i] = ST_HELD;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == DEB_TERM) begin
              state_d[i]     = ST_IDLE;
              cnt_d[i]       = '0;
              key_state_d[i] = 1'b0;
              release_d[i]   = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i]     = ST_IDLE;
            cnt_d[i]       = '0;
            key_state_d[i] = 1'b0;
          end
        endcase
      end
    end
    key_any_d = |key_state_d;
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= SYNC_RST;
      sync2_q     <= SYNC_RST;
      key_state_q <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      repeat_q    <= '0;
      key_any_q   <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
      key_any_q   <= key_any_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.key_state     = key_state_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.key_any       = key_any_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed scenarios plus random key activity,
// checked every cycle against a run-length reference model.
module tb_key_debounce_multi;

  localparam int unsigned NK  = 4;
  localparam int unsigned DEB = 8;
  localparam int unsigned LNG = 32;
  localparam int unsigned REP = 16;

  logic clk;
  logic rst_n;

  key_debounce_multi_if #(.NUM_KEYS(NK)) bus ();

  key_debounce_multi #(
    .NUM_KEYS(NK), .ACTIVE_LOW(1), .DEBOUNCE_CYC(DEB),
    .LONG_CYC(LNG), .REPEAT_CYC(REP), .CNT_W(18)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pad pipeline plus per-channel run lengths of stable samples.
  logic [NK-1:0] s1, s2;
  bit   pressed [NK];
  bit   longed  [NK];
  int   run     [NK];
  int   rel     [NK];
  int   hold    [NK];
  logic [NK-1:0] m_state, m_press, m_rel, m_long, m_rep;

  task automatic model_reset();
    s1 = '1; s2 = '1;
    m_state = '0; m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
    for (int c = 0; c < NK; c++) begin
      pressed[c] = 0; longed[c] = 0; run[c] = 0; rel[c] = 0; hold[c] = 0;
    end
  endtask

  task automatic model_step(input logic en_v, input logic [NK-1:0] key_v);
    logic [NK-1:0] p;
    p  = ~s2;
    s2 = s1;
    s1 = key_v;
    m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
    for (int c = 0; c < NK; c++) begin
      if (!en_v) begin
        pressed[c] = 0; longed[c] = 0; run[c] = 0; rel[c] = 0; hold[c] = 0;
      end else if (!pressed[c]) begin
        // Press accepted after DEB+1 consecutive pressed samples.
        if (p[c]) begin
          run[c]++;
          if (run[c] == DEB + 1) begin
            pressed[c] = 1; m_press[c] = 1'b1;
            run[c] = 0; rel[c] = 0; hold[c] = 0; longed[c] = 0;
          end
        end else begin
          run[c] = 0;
        end
      end else if (!p[c]) begin
        rel[c]++;
        if (rel[c] == DEB + 1) begin
          pressed[c] = 0; m_rel[c] = 1'b1; run[c] = 0; rel[c] = 0;
        end
      end else if (rel[c] > 0) begin
        // Release aborted by a bounce: hold timing restarts from here.
        rel[c] = 0; hold[c] = 0; longed[c] = 0;
      end else if (!longed[c]) begin
        hold[c]++;
        if (hold[c] == LNG) begin
          m_long[c] = 1'b1; longed[c] = 1; hold[c] = 0;
        end
      end else begin
        hold[c]++;
        if (hold[c] == REP) begin
          m_rep[c] = 1'b1; hold[c] = 0;
        end
      end
      m_state[c] = pressed[c];
    end
  endtask

  // Event log from DUT outputs, used for directed timing checks.
  int cyc = 0;
  int press_n [NK], rel_n [NK], long_n [NK], rep_n [NK];
  int ev_press [NK], ev_rel [NK], ev_long [NK], first_rep [NK], last_rep [NK];
  logic [NK-1:0] press_vec;

  task automatic clear_ev();
    press_vec = '0;
    for (int c = 0; c < NK; c++) begin
      press_n[c] = 0; rel_n[c] = 0; long_n[c] = 0; rep_n[c] = 0;
      ev_press[c] = -1; ev_rel[c] = -1; ev_long[c] = -1; first_rep[c] = -1; last_rep[c] = -1;
    end
  endtask

  task automatic check_outputs();
    check("key_state", 32'(bus.key_state),     32'(m_state));
    check("press",     32'(bus.press_pulse),   32'(m_press));
    check("release",   32'(bus.release_pulse), 32'(m_rel));
    check("long",      32'(bus.long_pulse),    32'(m_long));
    check("repeat",    32'(bus.repeat_pulse),  32'(m_rep));
    check("key_any",   32'(bus.key_any),       32'(|m_state));
  endtask

  task automatic step(input logic en_v, input logic [NK-1:0] key_v);
    bus.en = en_v;
    bus.key_in = key_v;
    @(posedge clk);
    model_step(en_v, key_v);
    cyc++;
    #1;
    check_outputs();
    if (bus.press_pulse != '0) press_vec = bus.press_pulse;
    for (int c = 0; c < NK; c++) begin
      if (bus.press_pulse[c])   begin press_n[c]++; ev_press[c] = cyc; end
      if (bus.release_pulse[c]) begin rel_n[c]++;   ev_rel[c]   = cyc; end
      if (bus.long_pulse[c])    begin long_n[c]++;  ev_long[c]  = cyc; end
      if (bus.repeat_pulse[c]) begin
        if (rep_n[c] == 0) first_rep[c] = cyc;
        rep_n[c]++; last_rep[c] = cyc;
      end
    end
  endtask

  task automatic steps(input int n, input logic en_v, input logic [NK-1:0] key_v);
    for (int k = 0; k < n; k++) step(en_v, key_v);
  endtask

  int t0;
  logic [NK-1:0] rkey;
  logic          ren;
  int            en_off;
  bit            noisy;

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.key_in = 4'hF;
    model_reset();
    clear_ev();
    #3;
    check("rst_key_state", 32'(bus.key_state), 32'd0);
    check("rst_key_any",   32'(bus.key_any),   32'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: released keys after reset stay quiet.
    steps(100, 1'b1, 4'hF);

    // 2: short press on ch0.
    clear_ev(); t0 = cyc + 1;
    steps(20, 1'b1, 4'hE);
    steps(20, 1'b1, 4'hF);
    check("t2_press_t",   32'(ev_press[0] - t0), 32'd10);
    check("t2_release_t", 32'(ev_rel[0] - t0),   32'd30);
    check("t2_press_n",   32'(press_n[0]),       32'd1);
    check("t2_long_rep",  32'(long_n[0] + rep_n[0]), 32'd0);
    steps(10, 1'b1, 4'hF);

    // 3: ch2 bounces shorter than debounce.
    clear_ev();
    for (int r = 0; r < 10; r++) begin
      steps(5, 1'b1, 4'hB);
      steps(5, 1'b1, 4'hF);
    end
    check("t3_pulses", 32'(press_n[2] + rel_n[2] + long_n[2] + rep_n[2]), 32'd0);

    // 4: long hold on ch1 with auto-repeat.
    clear_ev(); t0 = cyc + 1;
    steps(80, 1'b1, 4'hD);
    steps(20, 1'b1, 4'hF);
    check("t4_press_t",   32'(ev_press[1] - t0),  32'd10);
    check("t4_long_t",    32'(ev_long[1] - t0),   32'd42);
    check("t4_rep_first", 32'(first_rep[1] - t0), 32'd58);
    check("t4_rep_last",  32'(last_rep[1] - t0),  32'd74);
    check("t4_rep_n",     32'(rep_n[1]),          32'd2);
    check("t4_release_t", 32'(ev_rel[1] - t0),    32'd90);

    // 5: simultaneous presses on ch1 and ch3.
    clear_ev(); t0 = cyc + 1;
    steps(20, 1'b1, 4'h5);
    check("t5_press_vec", 32'(press_vec),   32'hA);
    check("t5_press_t",   32'(ev_press[3] - t0), 32'd10);
    steps(20, 1'b1, 4'hF);

    // 6: enable dropped while ch0 held, then re-qualified.
    clear_ev();
    steps(15, 1'b1, 4'hE);
    step(1'b0, 4'hE);
    check("t6_state_off", 32'(bus.key_state[0]), 32'd0);
    steps(2, 1'b0, 4'hE);
    t0 = cyc;
    steps(20, 1'b1, 4'hE);
    check("t6_no_release", 32'(rel_n[0]),          32'd0);
    check("t6_press_n",    32'(press_n[0]),        32'd2);
    check("t6_repress_t",  32'(ev_press[0] - t0),  32'd9);
    steps(20, 1'b1, 4'hF);

    // Asynchronous reset in the middle of a hold.
    steps(30, 1'b1, 4'hE);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(bus.key_state), 32'd0);
    check("midrst_any",   32'(bus.key_any),   32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    steps(30, 1'b1, 4'hE);
    steps(20, 1'b1, 4'hF);

    // Random key activity with bouncy stretches and enable drops.
    rkey = 4'hF; ren = 1'b1; en_off = 0; noisy = 0;
    for (int k = 0; k < 4000; k++) begin
      if (k % 200 == 0) noisy = ($urandom_range(0, 4) == 0);
      for (int c = 0; c < NK; c++)
        if ($urandom_range(0, 99) < (noisy ? 25 : 2)) rkey[c] = ~rkey[c];
      if (en_off > 0) en_off--;
      else if ($urandom_range(0, 299) == 0) en_off = $urandom_range(1, 4);
      ren = (en_off == 0);
      step(ren, rkey);
    end
    steps(40, 1'b1, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
